// File: rtl/mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl
// Sequencer for a 4:1 single-bit channel mux. It latches a data word onto the
// mux data input, then steps the mux select through every enabled channel in
// ascending order. It holds each channel for a programmable dwell and captures
// the mux output at the end of each dwell into a per-channel sample bit.
//
// Ports
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset, clears all state and outputs
//   start    : scan request, sampled only while idle
//   dwell    : cycles per channel (0 behaves as 1), captured on accepted start
//   en_mask  : per-channel enable, captured on accepted start
//   data_in  : word presented to the mux, captured on accepted start
//   mux_out  : output returned from the mux
//   In       : registered data word to the mux
//   sel      : registered channel select to the mux
//   valid    : high while a channel is being observed
//   busy     : high from the cycle after start acceptance through done
//   done     : one-cycle pulse at scan completion
//   sample   : captured mux output per channel (disabled channels read 0)
// -----------------------------------------------------------------------------
module mux_scan_ctrl #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [3:0]         en_mask,
   input  logic [3:0]         data_in,
   input  logic               mux_out,
   output logic [3:0]         In,
   output logic [1:0]         sel,
   output logic               valid,
   output logic               busy,
   output logic               done,
   output logic [3:0]         sample
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DWELL = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             r_state;
   logic [3:0]         r_in;
   logic [1:0]         r_sel;
   logic               r_valid;
   logic               r_busy;
   logic               r_done;
   logic [3:0]         r_sample;
   logic [3:0]         r_mask;
   logic [DWELL_W-1:0] r_deff;
   logic [DWELL_W-1:0] r_cnt;

   logic [DWELL_W-1:0] w_deff;
   logic               w_has_next;
   logic [1:0]         w_next_sel;

   // Index of the lowest set bit; only meaningful for a non-zero mask.
   function automatic logic [1:0] f_lowest(input logic [3:0] m);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   assign w_deff = (dwell == '0) ? DWELL_W'(1) : dwell;

   // Lowest enabled channel strictly above the current one (no wrap-around).
   always_comb begin
      w_has_next = 1'b0;
      w_next_sel = r_sel;
      for (int i = 3; i >= 0; i--) begin
         if (r_mask[i] && (i > int'(r_sel))) begin
            w_has_next = 1'b1;
            w_next_sel = 2'(i);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_in     <= '0;
         r_sel    <= '0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_sample <= '0;
         r_mask   <= '0;
         r_deff   <= '0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_in     <= data_in;
                  r_sample <= '0;
                  r_busy   <= 1'b1;
                  if (en_mask != 4'd0) begin
                     r_mask  <= en_mask;
                     r_deff  <= w_deff;
                     r_cnt   <= w_deff - DWELL_W'(1);
                     r_sel   <= f_lowest(en_mask);
                     r_valid <= 1'b1;
                     r_state <= S_DWELL;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end
            S_DWELL: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - DWELL_W'(1);
               end else begin
                  // Only the final dwell cycle samples the mux; earlier
                  // cycles give the mux path time to settle.
                  r_sample[r_sel] <= mux_out;
                  if (w_has_next) begin
                     r_sel <= w_next_sel;
                     r_cnt <= r_deff - DWELL_W'(1);
                  end else begin
                     r_valid <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign In     = r_in;
   assign sel    = r_sel;
   assign valid  = r_valid;
   assign busy   = r_busy;
   assign done   = r_done;
   assign sample = r_sample;

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Upstream sequencer for the 4:1 single-bit channel mux (ports `In[3:0]`, `sel[1:0]`, `Out`). It latches a 4-bit data word and drives it onto the mux data input. It then steps `sel` through every enabled channel, holding each one for a programmable dwell time. At the end of each dwell it captures the mux output into a per-channel sample register, so the scan result is a 4-bit word that can be checked against the latched input.

Parameters:
- DWELL_W, 8, width of the dwell-count input. Maximum dwell is 2^DWELL_W - 1 cycles.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high. Clears all state and outputs.
- start  in  1  scan request. Sampled only in IDLE.
- dwell  in  DWELL_W  cycles per channel, captured on an accepted start. Value 0 is treated as 1.
- en_mask  in  4  per-channel enable, captured on an accepted start. Bit i enables channel i.
- data_in  in  4  word to present to the mux, captured on an accepted start.
- mux_out  in  1  `Out` returned from the mux. Combinational path from `In`/`sel`.
- In  out  4  registered data word driven to the mux `In`.
- sel  out  2  registered channel select driven to the mux `sel`.
- valid  out  1  high while in DWELL, i.e. `sel` is stable and the mux output is being observed.
- busy  out  1  high from the cycle after start is accepted until DONE exits.
- done  out  1  single-cycle pulse at scan completion.
- sample  out  4  bit i = `mux_out` captured at the end of channel i's dwell. Bits of disabled channels are forced to 0.

Behaviour:
- Reset (async assert, sync release): state=IDLE; In=0, sel=0, valid=0, busy=0, done=0, sample=0; internal mask, dwell and counter = 0.
- FSM states: IDLE, DWELL, DONE.
- IDLE, start=1 and en_mask!=0:
  - register In<=data_in, mask<=en_mask, deff<=max(dwell,1), sample<=0;
  - sel<=index of the lowest set bit of en_mask; cnt<=deff-1; go to DWELL.
- IDLE, start=1 and en_mask==0: In<=data_in, sample<=0, go to DONE. No channel is visited.
- IDLE, start=0: hold all registers. `In` and `sample` retain the last scan's values.
- DWELL: valid=1, busy=1.
  - cnt!=0: cnt<=cnt-1.
  - cnt==0: sample[sel]<=mux_out.
    - If mask has a set bit above sel: sel<=next higher set index, cnt<=deff-1, stay in DWELL.
    - Otherwise go to DONE.
  - Scan order is strictly ascending, with no wrap-around.
- DONE: done=1, busy=1, valid=0 for exactly one cycle, then return to IDLE. sel holds its last value.
- Latency: start accepted at edge t0. With N enabled channels and dwell D, DWELL occupies N*D cycles and done is high in cycle t0+N*D+1. With N=0, done is high in cycle t0+1.
- Back-to-back: start may be asserted during the DONE cycle but is ignored. It is accepted in IDLE on the following cycle, so the minimum gap between done and the next busy is 1 cycle.
- start, dwell, en_mask and data_in changes while busy are ignored. Inputs are used only as captured.
- Reset asserted mid-scan: immediate return to reset values, with no done pulse. The scan is not resumed.
- `mux_out` is sampled only on the final cycle of each dwell. Glitches earlier in the dwell are ignored.

Test Plan:
- Reset mid-scan:
  - start with data_in=4'b1010, en_mask=4'b1111, dwell=3; assert rst at cycle 5 → all outputs 0 immediately, no done;
  - after release, state is IDLE and a fresh start runs normally.
- Full scan with the bench-modelled mux (mux_out=In[sel]):
  - start with data_in=4'b1010, en_mask=4'b1111, dwell=2 → sel goes 0,0,1,1,2,2,3,3 with valid high;
  - done in cycle t0+9; sample=4'b1010; busy low after done.
- Sparse mask: en_mask=4'b1001, dwell=1, data_in=4'b1111 → sel visits 0 then 3 only; sample=4'b1001; done at t0+3.
- Dwell zero and empty mask:
  - dwell=0, en_mask=4'b0100 → a single one-cycle visit to sel=2, done at t0+2;
  - en_mask=0 → done at t0+1, sample=0, valid never high.
- Ignored inputs and glitch:
  - toggle start, data_in and en_mask during a scan → no effect on sel sequence, In or sample;
  - force mux_out wrong on a non-final dwell cycle (dwell=4) → sample unaffected.
- Back-to-back: hold start=1 continuously, en_mask=4'b0011, dwell=1 → each done is followed by exactly one IDLE cycle, then busy reasserts; the second scan captures the new data_in.
